game_ctrl: RTL

//  Top-level Saper game sequencer: latches difficulty from level buttons, triggers mine

---
 rtl/game_ctrl_if.sv | 36 +++
 rtl/game_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/game_ctrl_if.sv
// Signal bundle between the Saper game sequencer and the button, board, setup and mine blocks.
interface game_ctrl_if;
  logic [2:0] btn_level;
  logic       restart;
  logic       setup_done;
  logic [5:0] mines;
  logic [8:0] board_cells;
  logic       reveal_pulse;
  logic       explode;
  logic       flag_set;
  logic       flag_clr;
  logic [1:0] level_out;
  logic       setup_start;
  logic       enable_game;
  logic       input_en;
  logic       flag_ok;
  logic [5:0] flags_left;
  logic [8:0] revealed_cnt;
  logic [9:0] time_sec;
  logic       game_won;
  logic       game_over;

  modport master (
    output btn_level, restart, setup_done, mines, board_cells, reveal_pulse, explode,
           flag_set, flag_clr,
    input  level_out, setup_start, enable_game, input_en, flag_ok, flags_left, revealed_cnt,
           time_sec, game_won, game_over
  );

  modport slave (
    input  btn_level, restart, setup_done, mines, board_cells, reveal_pulse, explode,
           flag_set, flag_clr,
    output level_out, setup_start, enable_game, input_en, flag_ok, flags_left, revealed_cnt,
           time_sec, game_won, game_over
  );
endinterface

// File: rtl/game_ctrl.sv
// Saper game sequencer: level latch, setup trigger, flag/reveal/timer tracking, win/loss.
// Optional GAME_CTRL_TIME_LIMIT_EN: reaching TIMER_MAX during play loses the game.
module game_ctrl #(
  parameter int unsigned CLK_FREQ  = 65_000_000,
  parameter int unsigned TIMER_MAX = 999
) (
  input logic        clk,
  input logic        rst,
  game_ctrl_if.slave bus
);
  localparam int unsigned PsW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PsW-1:0] PsLast = PsW'(CLK_FREQ - 1);
  localparam logic [9:0] TimeMax = 10'(TIMER_MAX);

  typedef enum logic [2:0] {StIdle, StSetup, StPlay, StWon, StLost} state_e;

  state_e         state_q, state_d;
  logic [1:0]     level_q, level_d;
  logic [PsW-1:0] presc_q, presc_d;
  logic [9:0]     time_q, time_d;
  logic [8:0]     revealed_q, revealed_d;
  logic [5:0]     flags_q, flags_d;
  logic           setup_start_q, setup_start_d;
  logic           flag_ok_q, flag_ok_d;
  logic           enable_game_q, enable_game_d;
  logic           input_en_q, input_en_d;
  logic           won_q, won_d;
  logic           over_q, over_d;
  logic [8:0]     rev_inc;
  logic           win, timeout;

  always_comb begin
    state_d       = state_q;
    level_d       = level_q;
    presc_d       = presc_q;
    time_d        = time_q;
    revealed_d    = revealed_q;
    flags_d       = flags_q;
    setup_start_d = 1'b0;
    flag_ok_d     = 1'b0;
    rev_inc       = (revealed_q == 9'd511) ? revealed_q : revealed_q + 9'd1;
    win           = 1'b0;
    timeout       = 1'b0;

    unique case (state_q)
      StIdle: begin
        presc_d    = '0;
        time_d     = '0;
        revealed_d = '0;
        flags_d    = '0;
        if (bus.btn_level != 3'b000) begin
          level_d       = {bus.btn_level[1] | bus.btn_level[0],
                           bus.btn_level[2] | bus.btn_level[0]};
          setup_start_d = 1'b1;
          state_d       = StSetup;
        end
      end
      StSetup: begin
        if (bus.restart) begin
          state_d = StIdle;
        end else if (bus.setup_done) begin
          flags_d = bus.mines;
          state_d = StPlay;
        end
      end
      StPlay: begin
        if (bus.restart) begin
          state_d = StIdle;
        end else begin
          if (presc_q == PsLast) begin
            presc_d = '0;
            if (time_q != TimeMax) time_d = time_q + 10'd1;
          end else begin
            presc_d = presc_q + PsW'(1);
          end
          timeout = (time_d == TimeMax) && (time_q != TimeMax);

          // Simultaneous set and clear cancel out.
          if (bus.flag_set && !bus.flag_clr) begin
            if (flags_q != 6'd0) begin
              flags_d   = flags_q - 6'd1;
              flag_ok_d = 1'b1;
            end
          end else if (bus.flag_clr && !bus.flag_set && flags_q != bus.mines) begin
            flags_d = flags_q + 6'd1;
          end

          if (bus.reveal_pulse) begin
            revealed_d = rev_inc;
            win        = (rev_inc == bus.board_cells - {3'b000, bus.mines});
          end

          if (bus.explode) begin
            state_d = StLost;
          end else if (win) begin
            state_d = StWon;
          end else if (timeout) begin
`ifdef GAME_CTRL_TIME_LIMIT_EN
            state_d = StLost;
`else
            state_d = StPlay;
`endif
          end
        end
      end
      StWon, StLost: begin
        if (bus.restart) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Leaving for IDLE drops every counter; only the level survives a restart.
    if (state_d == StIdle) begin
      presc_d    = '0;
      time_d     = '0;
      revealed_d = '0;
      flags_d    = '0;
    end

    enable_game_d = (state_d != StIdle);
    input_en_d    = (state_d == StPlay);
    won_d         = (state_d == StWon);
    over_d        = (state_d == StLost);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      level_q       <= '0;
      presc_q       <= '0;
      time_q        <= '0;
      revealed_q    <= '0;
      flags_q       <= '0;
      setup_start_q <= 1'b0;
      flag_ok_q     <= 1'b0;
      enable_game_q <= 1'b0;
      input_en_q    <= 1'b0;
      won_q         <= 1'b0;
      over_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      level_q       <= level_d;
      presc_q       <= presc_d;
      time_q        <= time_d;
      revealed_q    <= revealed_d;
      flags_q       <= flags_d;
      setup_start_q <= setup_start_d;
      flag_ok_q     <= flag_ok_d;
      enable_game_q <= enable_game_d;
      input_en_q    <= input_en_d;
      won_q         <= won_d;
      over_q        <= over_d;
    end
  end

  assign bus.level_out    = level_q;
  assign bus.setup_start  = setup_start_q;
  assign bus.enable_game  = enable_game_q;
  assign bus.input_en     = input_en_q;
  assign bus.flag_ok      = flag_ok_q;
  assign bus.flags_left   = flags_q;
  assign bus.revealed_cnt = revealed_q;
  assign bus.time_sec     = time_q;
  assign bus.game_won     = won_q;
  assign bus.game_over    = over_q;
endmodule
